// File: rtl/hex_digit_loader.sv
// hex_digit_loader
//   Enters hex digits from four switches into a four-digit shift display.
//   Each press of the load key shifts the digits up by one and places the
//   current switch value in DIGIT0. The clear key empties the display.
//   Both keys are raw, bouncing, active-low pushbuttons.
//
// Ports
//   CLOCK_50     in   1  system clock, rising edge
//   RESET        in   1  synchronous, active-high
//   SW           in   4  hex nibble to load (asynchronous)
//   KEY_LOAD     in   1  load pushbutton, active-low, raw
//   KEY_CLEAR    in   1  clear pushbutton, active-low, raw
//   DIGIT0..3    out  4  displayed nibbles, DIGIT0 newest
//   DIGIT_VALID  out  4  bit n set when DIGITn holds entered data
//   DIGIT_COUNT  out  3  digits entered, saturating at 4
//   LOAD_PULSE   out  1  one-cycle strobe per accepted load

// Debouncer: the stable state flips only after the synchronized input has
// differed from it for DEBOUNCE_CYCLES counts plus the terminal-count edge.
module hex_digit_loader_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic state
);

  localparam logic [19:0] TERMINAL = 20'(CYCLES);

  logic [19:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= 1'b1;
      cnt   <= '0;
    end else if (din == state) begin
      cnt <= '0;
    end else if (cnt == TERMINAL) begin
      state <= din;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 20'd1;
    end
  end

endmodule

module hex_digit_loader #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [3:0] SW,
  input  logic       KEY_LOAD,
  input  logic       KEY_CLEAR,
  output logic [3:0] DIGIT0,
  output logic [3:0] DIGIT1,
  output logic [3:0] DIGIT2,
  output logic [3:0] DIGIT3,
  output logic [3:0] DIGIT_VALID,
  output logic [2:0] DIGIT_COUNT,
  output logic       LOAD_PULSE
);

  logic [3:0] sw_s1, sw_s2;
  logic       load_s1, load_s2;
  logic       clear_s1, clear_s2;

  logic       load_db, clear_db;
  logic       load_db_d, clear_db_d;
  logic       load_event, clear_event;

  // Two-flop synchronizers; everything idles at released (1).
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_s1    <= 4'hF;
      sw_s2    <= 4'hF;
      load_s1  <= 1'b1;
      load_s2  <= 1'b1;
      clear_s1 <= 1'b1;
      clear_s2 <= 1'b1;
    end else begin
      sw_s1    <= SW;
      sw_s2    <= sw_s1;
      load_s1  <= KEY_LOAD;
      load_s2  <= load_s1;
      clear_s1 <= KEY_CLEAR;
      clear_s2 <= clear_s1;
    end
  end

  hex_digit_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .din   (load_s2),
    .state (load_db)
  );

  hex_digit_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .din   (clear_s2),
    .state (clear_db)
  );

  // Previous debounced state, so a press is a 1-to-0 edge and holding the
  // key never repeats.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      load_db_d  <= 1'b1;
      clear_db_d <= 1'b1;
    end else begin
      load_db_d  <= load_db;
      clear_db_d <= clear_db;
    end
  end

  assign load_event  = load_db_d  & ~load_db;
  assign clear_event = clear_db_d & ~clear_db;

  // Clear wins over a coincident load.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      DIGIT0      <= '0;
      DIGIT1      <= '0;
      DIGIT2      <= '0;
      DIGIT3      <= '0;
      DIGIT_VALID <= '0;
      DIGIT_COUNT <= '0;
      LOAD_PULSE  <= 1'b0;
    end else begin
      LOAD_PULSE <= 1'b0;
      if (clear_event) begin
        DIGIT0      <= '0;
        DIGIT1      <= '0;
        DIGIT2      <= '0;
        DIGIT3      <= '0;
        DIGIT_VALID <= '0;
        DIGIT_COUNT <= '0;
      end else if (load_event) begin
        DIGIT3      <= DIGIT2;
        DIGIT2      <= DIGIT1;
        DIGIT1      <= DIGIT0;
        DIGIT0      <= sw_s2;
        DIGIT_VALID <= {DIGIT_VALID[2:0], 1'b1};
        if (DIGIT_COUNT != 3'd4) begin
          DIGIT_COUNT <= DIGIT_COUNT + 3'd1;
        end
        LOAD_PULSE  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_digit_loader.sv
module tb_hex_digit_loader;

  localparam int DB = 4;
  localparam int LAT = DB + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       key_load, key_clear;
  logic [3:0] digit0, digit1, digit2, digit3, digit_valid;
  logic [2:0] digit_count;
  logic       load_pulse;

  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = -1;
  int total = 0;
  int bad = 0;

  // Reference model: the displayed digits as a simple list, newest first.
  logic [3:0] m_dig [4];
  logic [3:0] m_valid;
  logic [2:0] m_cnt;
  int         m_pulses = 0;

  hex_digit_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .SW          (sw),
    .KEY_LOAD    (key_load),
    .KEY_CLEAR   (key_clear),
    .DIGIT0      (digit0),
    .DIGIT1      (digit1),
    .DIGIT2      (digit2),
    .DIGIT3      (digit3),
    .DIGIT_VALID (digit_valid),
    .DIGIT_COUNT (digit_count),
    .LOAD_PULSE  (load_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records how many cycles the strobe was high and the
  // edge index of the most recent one.
  always @(posedge clk) begin
    #2;
    if (load_pulse === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_valid = 4'h0;
    m_cnt   = 3'd0;
  endtask

  task automatic model_load(input logic [3:0] v);
    for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
    m_dig[0] = v;
    m_valid  = {m_valid[2:0], 1'b1};
    if (m_cnt < 3'd4) m_cnt = m_cnt + 3'd1;
    m_pulses = m_pulses + 1;
  endtask

  function automatic logic [22:0] model_pack();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_valid, m_cnt};
  endfunction

  function automatic logic [22:0] dut_pack();
    return {digit3, digit2, digit1, digit0, digit_valid, digit_count};
  endfunction

  // Clean press: keys low for 'hold' samples, then released long enough
  // for the debouncers to return to idle. k is the first edge seeing low.
  task automatic press(input bit do_load, input bit do_clear,
                       input logic [3:0] v, input int hold, output int k);
    @(negedge clk);
    sw = v;
    if (do_load)  key_load  = 1'b0;
    if (do_clear) key_clear = 1'b0;
    k = cyc + 1;
    tick(hold);
    key_load  = 1'b1;
    key_clear = 1'b1;
    tick(12);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_clear();
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 4'h0; key_load = 1'b1; key_clear = 1'b1;
    model_clear();
    tick(4);
    total++;
    if (dut_pack() !== 23'h0) begin
      bad++; $display("FAIL reset_state: got %h want 0", dut_pack());
    end
    total++;
    if (load_pulse !== 1'b0) begin
      bad++; $display("FAIL reset_pulse: got %b want 0", load_pulse);
    end
    rst = 1'b0;
    tick(3);
    total++;
    if (pulse_cnt !== 0) begin
      bad++; $display("FAIL reset_no_pulse: got %0d want 0", pulse_cnt);
    end
  endtask

  task automatic test_load_sequence();
    int k;
    int p0;
    logic [3:0] vals [2];
    vals[0] = 4'hA; vals[1] = 4'h5;
    for (int i = 0; i < 2; i++) begin
      p0 = pulse_cnt;
      press(1'b1, 1'b0, vals[i], 10, k);
      model_load(vals[i]);
      total++;
      if (pulse_cnt !== p0 + 1) begin
        bad++; $display("FAIL load_seq pulses[%0d]: got %0d want %0d", i, pulse_cnt - p0, 1);
      end
      total++;
      if (pulse_cyc !== k + LAT) begin
        bad++; $display("FAIL load_seq latency[%0d]: got edge %0d want %0d", i, pulse_cyc, k + LAT);
      end
    end
    total++;
    if (dut_pack() !== {4'h0, 4'h0, 4'hA, 4'h5, 4'b0011, 3'd2}) begin
      bad++; $display("FAIL load_seq state: got %h want %h", dut_pack(), {4'h0, 4'h0, 4'hA, 4'h5, 4'b0011, 3'd2});
    end
  endtask

  task automatic test_bounce();
    int k;
    int p0;
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    p0 = pulse_cnt;
    @(negedge clk);
    sw = v;
    for (int i = 0; i < 10; i++) begin
      key_load = 1'b0; tick(2);
      key_load = 1'b1; tick(2);
    end
    key_load = 1'b0;
    k = cyc + 1;
    tick(20);
    key_load = 1'b1;
    tick(12);
    model_load(v);
    total++;
    if (pulse_cnt !== p0 + 1) begin
      bad++; $display("FAIL bounce pulses: got %0d want 1", pulse_cnt - p0);
    end
    total++;
    if (pulse_cyc !== k + LAT) begin
      bad++; $display("FAIL bounce latency: got edge %0d want %0d", pulse_cyc, k + LAT);
    end
    total++;
    if (dut_pack() !== model_pack()) begin
      bad++; $display("FAIL bounce state: got %h want %h", dut_pack(), model_pack());
    end
  endtask

  task automatic test_overflow();
    int k;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      press(1'b1, 1'b0, 4'(i), 8, k);
      model_load(4'(i));
    end
    total++;
    if (dut_pack() !== {4'h2, 4'h3, 4'h4, 4'h5, 4'b1111, 3'd4}) begin
      bad++; $display("FAIL overflow state: got %h want %h", dut_pack(), {4'h2, 4'h3, 4'h4, 4'h5, 4'b1111, 3'd4});
    end
    total++;
    if (dut_pack() !== model_pack()) begin
      bad++; $display("FAIL overflow model: got %h want %h", dut_pack(), model_pack());
    end
  endtask

  task automatic test_clear_priority();
    int k;
    int p0;
    for (int i = 0; i < 3; i++) begin
      logic [3:0] v;
      v = 4'($urandom_range(1, 15));
      press(1'b1, 1'b0, v, 8, k);
      model_load(v);
    end
    total++;
    if (dut_pack() !== model_pack()) begin
      bad++; $display("FAIL clear_prio pre: got %h want %h", dut_pack(), model_pack());
    end
    p0 = pulse_cnt;
    press(1'b1, 1'b1, 4'($urandom_range(0, 15)), 10, k);
    model_clear();
    total++;
    if (pulse_cnt !== p0) begin
      bad++; $display("FAIL clear_prio pulse: got %0d want 0", pulse_cnt - p0);
    end
    total++;
    if (dut_pack() !== 23'h0) begin
      bad++; $display("FAIL clear_prio state: got %h want 0", dut_pack());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    int r;
    int p0;
    logic [3:0] v;
    press(1'b1, 1'b0, 4'h7, 8, k);
    model_load(4'h7);
    v = 4'($urandom_range(0, 15));
    p0 = pulse_cnt;
    @(negedge clk);
    sw = v;
    key_load = 1'b0;
    k = cyc + 1;
    tick(3);
    rst = 1'b1;
    r = cyc + 1;
    tick(1);
    rst = 1'b0;
    model_clear();
    total++;
    if (dut_pack() !== 23'h0 || load_pulse !== 1'b0) begin
      bad++; $display("FAIL reset_mid cleared: got %h/%b want 0/0", dut_pack(), load_pulse);
    end
    tick(15);
    key_load = 1'b1;
    tick(12);
    model_load(v);
    total++;
    if (pulse_cnt !== p0 + 1) begin
      bad++; $display("FAIL reset_mid pulses: got %0d want 1", pulse_cnt - p0);
    end
    total++;
    if (pulse_cyc !== r + 1 + LAT) begin
      bad++; $display("FAIL reset_mid latency: got edge %0d want %0d", pulse_cyc, r + 1 + LAT);
    end
    total++;
    if (dut_pack() !== model_pack()) begin
      bad++; $display("FAIL reset_mid state: got %h want %h", dut_pack(), model_pack());
    end
  endtask

  task automatic test_hold();
    int k;
    int p0;
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    p0 = pulse_cnt;
    @(negedge clk);
    sw = v;
    key_load = 1'b0;
    k = cyc + 1;
    tick(20);
    for (int i = 0; i < 98; i++) begin
      sw = 4'($urandom_range(0, 15));
      tick(10);
    end
    key_load = 1'b1;
    tick(12);
    model_load(v);
    total++;
    if (pulse_cnt !== p0 + 1) begin
      bad++; $display("FAIL hold pulses: got %0d want 1", pulse_cnt - p0);
    end
    total++;
    if (pulse_cyc !== k + LAT) begin
      bad++; $display("FAIL hold latency: got edge %0d want %0d", pulse_cyc, k + LAT);
    end
    total++;
    if (dut_pack() !== model_pack()) begin
      bad++; $display("FAIL hold state: got %h want %h", dut_pack(), model_pack());
    end
  endtask

  // Random mix of clean loads, clean clears, short glitches and bare
  // switch changes; only clean presses may change the display.
  task automatic test_random();
    int k;
    int p0;
    int act;
    int len;
    logic [3:0] v;
    for (int it = 0; it < 40; it++) begin
      act = $urandom_range(0, 4);
      v   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, DB);
      p0  = pulse_cnt;
      case (act)
        0: begin
          press(1'b1, 1'b0, v, $urandom_range(DB + 1, DB + 8), k);
          model_load(v);
          total++;
          if (pulse_cyc !== k + LAT) begin
            bad++; $display("FAIL random[%0d] latency: got edge %0d want %0d", it, pulse_cyc, k + LAT);
          end
        end
        1: begin
          press(1'b0, 1'b1, v, $urandom_range(DB + 1, DB + 8), k);
          model_clear();
        end
        2, 3: begin
          @(negedge clk);
          sw = v;
          if (act == 2) key_load = 1'b0; else key_clear = 1'b0;
          tick(len);
          key_load = 1'b1; key_clear = 1'b1;
          tick(8);
        end
        default: begin
          @(negedge clk);
          sw = v;
          tick(6);
        end
      endcase
      total++;
      if (pulse_cnt !== m_pulses) begin
        bad++; $display("FAIL random[%0d] act %0d pulses: got %0d want %0d", it, act, pulse_cnt, m_pulses);
      end
      total++;
      if (dut_pack() !== model_pack()) begin
        bad++; $display("FAIL random[%0d] act %0d state: got %h want %h", it, act, dut_pack(), model_pack());
      end
      if (pulse_cnt != m_pulses) m_pulses = pulse_cnt;
    end
  endtask

  initial begin
    test_reset();
    test_load_sequence();
    test_bounce();
    test_overflow();
    test_clear_priority();
    test_reset_mid();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_digit_loader.md
HEX_DIGIT_LOADER -- requirements
Module: hex_digit_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL be the number of consecutive stable synchronized samples required to accept a key change (10 ms at 50 MHz), with a legal range of 1 to 2^20-1.
REQ-002 CLOCK_50  input  1  SHALL be the single clock; all state is on its rising edge.
REQ-003 RESET  input  1  SHALL be a synchronous, active-high reset.
REQ-004 SW  input  4  SHALL be the hex nibble to load, asynchronous to CLOCK_50.
REQ-005 KEY_LOAD  input  1  SHALL be the load pushbutton, active-low, raw and bouncing.
REQ-006 KEY_CLEAR  input  1  SHALL be the clear pushbutton, active-low, raw and bouncing.
REQ-007 DIGIT0..DIGIT3  output  4 each  SHALL be the registered nibbles, each driving one downstream hex-to-7-segment decoder; DIGIT0 is the newest digit.
REQ-008 DIGIT_VALID  output  4  SHALL mark which DIGITn hold entered data (bit n for DIGITn); downstream blanks HEXn when its bit is 0.
REQ-009 DIGIT_COUNT  output  3  SHALL be the number of digits entered, saturating at 4.
REQ-010 LOAD_PULSE  output  1  SHALL be a one-cycle strobe for each accepted load.

Function
REQ-011 SW, KEY_LOAD and KEY_CLEAR SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Each key SHALL have its own debouncer: a counter plus a stable-state flop, with the stable state initialised to released (1).
  - Counter clears whenever the synchronized input equals the stable state.
  - Counter increments while the two differ.
  - On reaching DEBOUNCE_CYCLES, the stable state takes the input value and the counter clears.
REQ-013 A press event SHALL be a 1-to-0 transition of the debounced state; releases generate no event.
REQ-014 Latency: with a raw key held low from edge k, the debounced state SHALL fall at edge k+2+DEBOUNCE_CYCLES and the resulting action SHALL take effect at edge k+3+DEBOUNCE_CYCLES.
REQ-015 A load event SHALL perform all of the following on one edge:
  - DIGIT3<=DIGIT2, DIGIT2<=DIGIT1, DIGIT1<=DIGIT0, DIGIT0<=synchronized SW.
  - DIGIT_VALID<={DIGIT_VALID[2:0],1}.
  - DIGIT_COUNT increments, saturating at 4.
  - LOAD_PULSE=1 for exactly that cycle.
REQ-016 On the 5th and later loads, DIGIT3 SHALL be discarded, DIGIT_VALID SHALL stay 4'b1111 and DIGIT_COUNT SHALL stay 4.
REQ-017 A clear event SHALL set all DIGITn=0, DIGIT_VALID=0 and DIGIT_COUNT=0, and SHALL leave LOAD_PULSE=0.
REQ-018 Simultaneous load and clear events on the same edge SHALL perform the clear only, with LOAD_PULSE=0.
REQ-019 A key held down indefinitely SHALL produce exactly one event; there is no auto-repeat.
REQ-020 Bounces shorter than DEBOUNCE_CYCLES consecutive cycles SHALL produce no event.
REQ-021 SW changes SHALL not affect the outputs except through a load event.

Reset
REQ-022 While RESET=1 at an edge, the block SHALL set:
  - all DIGITn=0, DIGIT_VALID=0, DIGIT_COUNT=0, LOAD_PULSE=0;
  - synchronizer flops and debounced states to 1 (released);
  - debounce counters to 0.
REQ-023 RESET asserted mid-debounce or mid-pulse SHALL discard the pending event; a key still held low after RESET deasserts SHALL be debounced afresh and produce one event.
REQ-024 RESET SHALL take priority over load and clear events.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Load sequence: SW=A, press KEY_LOAD cleanly, release; repeat with SW=5 -> DIGIT0=5, DIGIT1=A, DIGIT_VALID=0011, DIGIT_COUNT=2, two LOAD_PULSEs, each landing exactly 7 cycles after its press.
REQ-026 Bounce rejection: KEY_LOAD toggling every 2 cycles for 40 cycles, then steady low -> exactly one LOAD_PULSE, occurring 7 cycles after the final 1-to-0 raw edge.
REQ-027 Overflow: loads of 1,2,3,4,5 -> DIGIT3..0=2,3,4,5, DIGIT_VALID=1111, DIGIT_COUNT=4.
REQ-028 Clear priority: after 3 loads, debounced load and clear events on the same edge -> all DIGITn=0, DIGIT_VALID=0000, DIGIT_COUNT=0, no LOAD_PULSE.
REQ-029 Reset mid-operation: RESET for 1 cycle 3 cycles after a KEY_LOAD press, key still held -> outputs zero, then exactly one LOAD_PULSE 7 cycles after RESET deasserts.
REQ-030 Hold: KEY_LOAD held low for 1000 cycles -> exactly one LOAD_PULSE, and DIGIT0 ignores SW changes made after the pulse.
